// File: rtl/mpdmac_apb_master.sv
// mpdmac_apb_master
// APB3 requester for the MPDMAC configuration slave. A valid/ready command
// becomes one SETUP + ACCESS transfer. Read data and error status come back
// on a valid/ready response channel. Only one transfer is in flight at a time.
// Every APB and response output comes straight from a flop.

module mpdmac_apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    // response channel
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    // APB3 requester
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    // TIMEOUT is limited to 0..255, so an 8-bit ACCESS counter is enough.
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic                timeout_hit_d;
    logic [DATA_W-1:0]   rsp_rdata_d;

    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                psel_q;
    logic                penable_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;

    // Next-count, timeout detection and read-data selection for the ACCESS phase.
    always_comb begin
        cnt_d         = cnt_q + 8'd1;
        // cnt_d is the number of the ACCESS cycle now in progress (1-based).
        timeout_hit_d = TIMEOUT_EN && (cnt_d == TIMEOUT_C);
        rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
    end

    // Transfer FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (cmd_valid_i && cmd_ready_q) begin
                        // The command is captured once here and not sampled again.
                        paddr_q     <= cmd_addr_i;
                        pwrite_q    <= cmd_write_i;
                        pwdata_q    <= cmd_wdata_i;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end else begin
                        // The first cycle after reset raises ready.
                        cmd_ready_q <= 1'b1;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    cnt_q <= cnt_d;
                    // pready is checked before the timeout. A slave that answers
                    // on the last allowed cycle completes normally.
                    if (pready_i) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= pslverr_i;
                        state_q     <= RESP;
                    end else if (timeout_hit_d) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    // Response data stays put until it is taken.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        cnt_q       <= 8'd0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    cnt_q       <= 8'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign paddr_o     = paddr_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_mpdmac_apb_master.sv
// tb_mpdmac_apb_master
// Self-checking bench for mpdmac_apb_master. It uses a behavioural APB slave,
// a table of directed transfers with literal expectations, hand-written
// reset sequences, and randomized transfers checked against a
// transaction-level model.

module tb_mpdmac_apb_master;

    localparam int          TO      = 16;
    localparam logic [31:0] VERSION = 32'h0101_2025;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        psel_o;
    logic        penable_o;
    logic [11:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    mpdmac_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural APB slave ----------------
    int          s_ws;      // ACCESS cycles with pready low before answering
    bit          s_hang;    // never answer
    bit          s_err;     // answer with pslverr
    int          s_acc;     // ACCESS cycles already seen in this transfer
    logic [31:0] smem [4096] = '{default: 32'h0};

    always_comb begin
        pready_i  = 1'b0;
        prdata_i  = 32'h0;
        pslverr_i = 1'b0;
        if (psel_o && penable_o) begin
            pready_i  = !s_hang && (s_acc >= s_ws);
            prdata_i  = (paddr_o == 12'h000) ? VERSION : smem[paddr_o];
            pslverr_i = s_err && pready_i;
        end
    end

    always @(posedge clk) begin
        if (psel_o && penable_o) begin
            if (pready_i) begin
                s_acc <= 0;
                if (pwrite_o && !s_err && paddr_o != 12'h000) smem[paddr_o] <= pwdata_o;
            end else begin
                s_acc <= s_acc + 1;
            end
        end else begin
            s_acc <= 0;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] model_mem [int];

    function automatic bit model_timed_out(input int ws, input bit hang);
        return hang || (ws + 1 > TO);
    endfunction

    function automatic int model_acc(input int ws, input bit hang);
        return model_timed_out(ws, hang) ? TO : ws + 1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic w, input logic [11:0] a,
                                                input int ws, input bit hang);
        if (w || model_timed_out(ws, hang)) return 32'h0;
        if (a == 12'h000) return VERSION;
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 32'h0;
    endfunction

    function automatic logic model_err(input int ws, input bit hang, input bit err);
        return model_timed_out(ws, hang) ? 1'b1 : err;
    endfunction

    task automatic model_apply(input logic w, input logic [11:0] a, input logic [31:0] d,
                               input int ws, input bit hang, input bit err);
        if (w && !err && !model_timed_out(ws, hang) && a != 12'h000)
            model_mem[int'(a)] = d;
    endtask

    // ---------------- checking helpers ----------------
    int n_vec;
    int n_err;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one command end to end. It reports what the DUT returned and how many
    // protocol rules were broken along the way.
    task automatic do_cmd(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input int ws, input bit hang, input bit err, input int hold,
                          output logic [31:0] r_data, output logic r_err,
                          output int acc, output int lat, output int bad,
                          output int psel_cyc, output bit to);
        int guard;
        s_ws = ws; s_hang = hang; s_err = err;
        acc = 0; lat = 0; bad = 0; psel_cyc = -1; to = 1'b0;
        r_data = 32'h0; r_err = 1'b0;
        cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d; cmd_valid_i = 1'b1;
        guard = 0;
        while (!cmd_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        if (!cmd_ready_o) begin
            to = 1'b1;
            cmd_valid_i = 1'b0;
            return;
        end
        tick();
        // Scramble the command bus so any re-sampling would show up on APB.
        cmd_valid_i = 1'b0; cmd_write_i = ~w; cmd_addr_i = ~a; cmd_wdata_i = ~d;
        lat = 1;
        while (!rsp_valid_o && lat < 300) begin
            if (!psel_o) bad++;
            else begin
                if (psel_cyc < 0) psel_cyc = cyc;
                if (paddr_o !== a || pwrite_o !== w || pwdata_o !== d) bad++;
            end
            if (penable_o) acc++;
            if (lat == 1 && penable_o) bad++;
            if (lat > 1 && !penable_o) bad++;
            if (cmd_ready_o) bad++;
            tick();
            lat++;
        end
        if (!rsp_valid_o) begin
            to = 1'b1;
            return;
        end
        if (psel_o || penable_o || cmd_ready_o) bad++;
        r_data = rsp_rdata_o;
        r_err  = rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = 1'b0;
            tick();
            if (!rsp_valid_o || rsp_rdata_o !== r_data || rsp_err_o !== r_err ||
                cmd_ready_o || psel_o) bad++;
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        if (rsp_valid_o || !cmd_ready_o) bad++;
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        int          ws;
        bit          hang;
        bit          err;
        int          hold;
        logic [31:0] xr;
        logic        xe;
        int          xacc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] r_data;
        logic        r_err;
        int          acc, lat, bad, pc, prev_pc;
        bit          to;

        n_vec = 0; n_err = 0; cyc = 0;
        s_ws = 0; s_hang = 1'b0; s_err = 1'b0;
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
        cmd_addr_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b0;

        //        w     addr     wdata         ws  hang  err  hold  exp_rdata     err   acc
        tbl[0]  = '{1'b1, 12'h100, 32'h1234_5678, 0,  1'b0, 1'b0, 0, 32'h0,         1'b0, 1};
        tbl[1]  = '{1'b0, 12'h000, 32'h0,         0,  1'b0, 1'b0, 0, 32'h0101_2025, 1'b0, 1};
        tbl[2]  = '{1'b0, 12'h100, 32'h0,         0,  1'b0, 1'b0, 0, 32'h1234_5678, 1'b0, 1};
        tbl[3]  = '{1'b1, 12'h104, 32'hCAFE_F00D, 3,  1'b0, 1'b0, 0, 32'h0,         1'b0, 4};
        tbl[4]  = '{1'b0, 12'h104, 32'h0,         3,  1'b0, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 4};
        tbl[5]  = '{1'b0, 12'h108, 32'h0,         0,  1'b1, 1'b0, 0, 32'h0,         1'b1, 16};
        tbl[6]  = '{1'b0, 12'h100, 32'h0,         15, 1'b0, 1'b0, 0, 32'h1234_5678, 1'b0, 16};
        tbl[7]  = '{1'b1, 12'h10C, 32'h0000_DEAD, 0,  1'b0, 1'b1, 5, 32'h0,         1'b1, 1};
        tbl[8]  = '{1'b0, 12'h10C, 32'h0,         0,  1'b0, 1'b0, 0, 32'h0,         1'b0, 1};
        tbl[9]  = '{1'b0, 12'h100, 32'h0,         0,  1'b0, 1'b1, 5, 32'h1234_5678, 1'b1, 1};
        tbl[10] = '{1'b1, 12'h108, 32'h0000_0055, 0,  1'b1, 1'b0, 0, 32'h0,         1'b1, 16};
        tbl[11] = '{1'b0, 12'h108, 32'h0,         0,  1'b0, 1'b0, 0, 32'h0,         1'b0, 1};
        tbl[12] = '{1'b1, 12'h110, 32'h0000_A5A5, 1,  1'b0, 1'b0, 2, 32'h0,         1'b0, 2};
        tbl[13] = '{1'b0, 12'h110, 32'h0,         16, 1'b0, 1'b0, 0, 32'h0,         1'b1, 16};

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_psel",      32'(psel_o),      32'h0);
        chk("rst_penable",   32'(penable_o),   32'h0);
        chk("rst_paddr",     32'(paddr_o),     32'h0);
        chk("rst_pwrite",    32'(pwrite_o),    32'h0);
        chk("rst_pwdata",    pwdata_o,         32'h0);
        chk("rst_rdata",     rsp_rdata_o,      32'h0);
        chk("rst_err",       32'(rsp_err_o),   32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'h1);

        // ---- directed table ----
        prev_pc = 0;
        for (int i = 0; i < 14; i++) begin
            do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ws, tbl[i].hang, tbl[i].err,
                   tbl[i].hold, r_data, r_err, acc, lat, bad, pc, to);
            model_apply(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ws, tbl[i].hang, tbl[i].err);
            chk($sformatf("tbl%0d_done", i),  32'(to),    32'h0);
            chk($sformatf("tbl%0d_rdata", i), r_data,     tbl[i].xr);
            chk($sformatf("tbl%0d_err", i),   32'(r_err), 32'(tbl[i].xe));
            chk($sformatf("tbl%0d_acc", i),   32'(acc),   32'(tbl[i].xacc));
            chk($sformatf("tbl%0d_lat", i),   32'(lat),   32'(2 + tbl[i].xacc));
            chk($sformatf("tbl%0d_proto", i), 32'(bad),   32'h0);
            if (i == 1 || i == 2)
                chk($sformatf("tbl%0d_psel_spacing", i), 32'(pc - prev_pc), 32'd4);
            prev_pc = pc;
        end

        // ---- reset in the middle of ACCESS ----
        s_ws = 0; s_hang = 1'b1; s_err = 1'b0;
        cmd_write_i = 1'b0; cmd_addr_i = 12'h104; cmd_wdata_i = 32'h0; cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("mid_rst_in_access", 32'(psel_o && penable_o), 32'h1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_psel",      32'(psel_o),      32'h0);
        chk("mid_rst_penable",   32'(penable_o),   32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        rst_n = 1'b1;
        s_hang = 1'b0;
        tick();
        chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
        chk("mid_rst_rsp_valid2", 32'(rsp_valid_o), 32'h0);
        do_cmd(1'b0, 12'h104, 32'h0, 0, 1'b0, 1'b0, 0, r_data, r_err, acc, lat, bad, pc, to);
        chk("after_rst_done",  32'(to),    32'h0);
        chk("after_rst_rdata", r_data,     32'hCAFE_F00D);
        chk("after_rst_err",   32'(r_err), 32'h0);
        chk("after_rst_lat",   32'(lat),   32'd3);
        chk("after_rst_proto", 32'(bad),   32'h0);

        // ---- randomized transfers against the model ----
        for (int k = 0; k < 60; k++) begin
            logic        w;
            logic [11:0] a;
            logic [31:0] d;
            int          ws, hold, sel;
            bit          hang, err;
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: a = 12'h000;
                1: a = 12'h100;
                2: a = 12'h104;
                3: a = 12'h108;
                4: a = 12'h10C;
                5: a = 12'h110;
                default: a = 12'($urandom);
            endcase
            w    = 1'($urandom);
            d    = $urandom;
            ws   = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ws = int'($urandom_range(14, 17));
            hang = ($urandom_range(0, 9) == 0);
            err  = ($urandom_range(0, 5) == 0);
            hold = int'($urandom_range(0, 3));
            do_cmd(w, a, d, ws, hang, err, hold, r_data, r_err, acc, lat, bad, pc, to);
            chk($sformatf("rnd%0d_done", k),  32'(to),    32'h0);
            chk($sformatf("rnd%0d_rdata", k), r_data,     model_rdata(w, a, ws, hang));
            chk($sformatf("rnd%0d_err", k),   32'(r_err), 32'(model_err(ws, hang, err)));
            chk($sformatf("rnd%0d_acc", k),   32'(acc),   32'(model_acc(ws, hang)));
            chk($sformatf("rnd%0d_lat", k),   32'(lat),   32'(2 + model_acc(ws, hang)));
            chk($sformatf("rnd%0d_proto", k), 32'(bad),   32'h0);
            model_apply(w, a, d, ws, hang, err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
